// File: rtl/cnt_capture_pkg.sv
// ============================================================================
// Module   : cnt_capture_pkg
// Purpose  : Shared types and constants for the cnt_capture_buf slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_capture_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int          SAMPLE_W     = 19;
   localparam logic [15:0] TRIG_CNT     = 16'h0000;
   localparam logic [15:0] TRIG_CNT_DLY = 16'hFFFF;

   function automatic logic [SAMPLE_W-1:0] make_sample(input logic        toggle,
                                                       input logic        one_fifty,
                                                       input logic        hundred,
                                                       input logic [15:0] cnt);
      return {toggle, one_fifty, hundred, cnt};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_capture_ram.sv
// ============================================================================
// Module   : cnt_capture_ram
// Purpose  : Simple dual-port ring storage, one write port, registered read
//            with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_capture_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 19
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

`default_nettype wire

// File: rtl/cnt_capture_buf.sv
// ============================================================================
// Module   : cnt_capture_buf
// Purpose  : Trigger-positioned capture of the cnt_demo outputs into a ring,
//            streamed out over valid/ready. Optional checker: CNT_CONSISTENCY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_capture_buf
   import cnt_capture_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int PRE_DEPTH = 128
) (
   input  logic                osc_ext,
   input  logic                reset,
   input  logic                arm,
   input  logic [15:0]         cnt_in,
   input  logic [15:0]         cnt_dly_in,
   input  logic                hundred,
   input  logic                one_fifty,
   input  logic                toggle,
   output logic                busy,
   output logic                trig_seen,
   output logic                rd_valid,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic                rd_last,
   input  logic                rd_ready,
   output logic                cnt_err
);

   localparam int              AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]   PRE_LAST  = AW'(PRE_DEPTH - 1);
   localparam logic [AW-1:0]   POST_LAST = AW'(DEPTH - PRE_DEPTH - 1);
   localparam logic [AW-1:0]   PRE_OFS   = AW'(PRE_DEPTH);
   localparam logic [AW:0]     RD_TOTAL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]     RD_LAST   = (AW+1)'(DEPTH - 1);

   state_t                state;
   logic [AW-1:0]         wr_addr;
   logic [AW-1:0]         trig_addr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         phase_cnt;
   logic [AW:0]           rd_cnt;
   logic                  wr_en;
   logic                  trig;
   logic [SAMPLE_W-1:0]   sample;
   logic [SAMPLE_W-1:0]   q_data;
   logic                  q_valid;
   logic                  q_last;
   logic [SAMPLE_W-1:0]   pf_data;
   logic                  pf_valid;
   logic                  pf_last;
   logic                  accept;
   logic                  issue;
   logic [1:0]            occ_after;

   assign wr_en  = (state == PRE) || (state == WAIT) || (state == POST);
   assign trig   = (cnt_in == TRIG_CNT) && (cnt_dly_in == TRIG_CNT_DLY);
   assign sample = make_sample(toggle, one_fifty, hundred, cnt_in);
   assign busy   = (state != IDLE);
   assign accept = rd_valid && rd_ready;

   // Words held after this edge (output + prefetch + landing RAM word); a new
   // read is only issued if its result is guaranteed a slot when it lands.
   always_comb begin
      occ_after = {1'b0, rd_valid} + {1'b0, pf_valid} + {1'b0, q_valid} - {1'b0, accept};
      issue     = (state == DONE) && (rd_cnt != RD_TOTAL) && (occ_after <= 2'd1);
   end

   cnt_capture_ram #(
      .DEPTH (DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_ram (
      .clk   (osc_ext),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (sample),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (q_data)
   );

   always_ff @(posedge osc_ext) begin
      if (reset) begin
         state     <= IDLE;
         wr_addr   <= '0;
         trig_addr <= '0;
         rd_ptr    <= '0;
         phase_cnt <= '0;
         trig_seen <= 1'b0;
      end else begin
         case (state)
            IDLE: if (arm) begin
               state     <= PRE;
               wr_addr   <= '0;
               phase_cnt <= '0;
            end
            PRE: begin
               wr_addr   <= wr_addr + 1'b1;
               phase_cnt <= phase_cnt + 1'b1;
               if (phase_cnt == PRE_LAST) state <= WAIT;
            end
            WAIT: begin
               wr_addr <= wr_addr + 1'b1;
               if (trig) begin
                  trig_addr <= wr_addr;
                  trig_seen <= 1'b1;
                  phase_cnt <= AW'(1);
                  if (POST_LAST == '0) begin
                     state  <= DONE;
                     rd_ptr <= wr_addr - PRE_OFS;
                  end else begin
                     state <= POST;
                  end
               end
            end
            POST: begin
               wr_addr   <= wr_addr + 1'b1;
               phase_cnt <= phase_cnt + 1'b1;
               if (phase_cnt == POST_LAST) begin
                  state  <= DONE;
                  rd_ptr <= trig_addr - PRE_OFS;
               end
            end
            DONE: begin
               if (issue) rd_ptr <= rd_ptr + 1'b1;
               if (accept && rd_last) begin
                  state     <= IDLE;
                  trig_seen <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge osc_ext) begin
      if (reset) begin
         rd_cnt   <= '0;
         q_valid  <= 1'b0;
         q_last   <= 1'b0;
         pf_data  <= '0;
         pf_valid <= 1'b0;
         pf_last  <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
      end else if (state == IDLE) begin
         rd_cnt   <= '0;
         q_valid  <= 1'b0;
         q_last   <= 1'b0;
         pf_valid <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         q_valid <= issue;
         q_last  <= issue && (rd_cnt == RD_LAST);
         if (issue) rd_cnt <= rd_cnt + 1'b1;
         if (!rd_valid || rd_ready) begin
            if (pf_valid) begin
               rd_data  <= pf_data;
               rd_last  <= pf_last;
               rd_valid <= 1'b1;
               pf_data  <= q_data;
               pf_last  <= q_last;
               pf_valid <= q_valid;
            end else if (q_valid) begin
               rd_data  <= q_data;
               rd_last  <= q_last;
               rd_valid <= 1'b1;
            end else begin
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         end else if (q_valid) begin
            pf_data  <= q_data;
            pf_last  <= q_last;
            pf_valid <= 1'b1;
         end
      end
   end

`ifdef CNT_CONSISTENCY_CHK_EN
   logic err_flag;

   always_ff @(posedge osc_ext) begin
      if (reset) begin
         err_flag <= 1'b0;
      end else if ((state == IDLE) && arm) begin
         err_flag <= 1'b0;
      end else if (wr_en && (cnt_in != cnt_dly_in + 16'd1)) begin
         err_flag <= 1'b1;
      end
   end

   assign cnt_err = err_flag;
`else
   assign cnt_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cnt_capture_buf.sv
// ============================================================================
// Module   : tb_cnt_capture_buf
// Purpose  : Directed self-checking bench for cnt_capture_buf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_capture_buf;
   import cnt_capture_pkg::*;

   localparam int DEPTH     = 256;
   localparam int PRE_DEPTH = 128;
`ifdef CNT_CONSISTENCY_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic                osc_ext;
   logic                reset;
   logic                arm;
   logic [15:0]         cnt_in;
   logic [15:0]         cnt_dly_in;
   logic                hundred;
   logic                one_fifty;
   logic                toggle;
   logic                busy;
   logic                trig_seen;
   logic                rd_valid;
   logic [SAMPLE_W-1:0] rd_data;
   logic                rd_last;
   logic                rd_ready;
   logic                cnt_err;

   int n_cmp = 0;
   int n_err = 0;

   cnt_capture_buf #(
      .DEPTH     (DEPTH),
      .PRE_DEPTH (PRE_DEPTH)
   ) dut (
      .osc_ext    (osc_ext),
      .reset      (reset),
      .arm        (arm),
      .cnt_in     (cnt_in),
      .cnt_dly_in (cnt_dly_in),
      .hundred    (hundred),
      .one_fifty  (one_fifty),
      .toggle     (toggle),
      .busy       (busy),
      .trig_seen  (trig_seen),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_last    (rd_last),
      .rd_ready   (rd_ready),
      .cnt_err    (cnt_err)
   );

   initial osc_ext = 1'b0;
   always #5 osc_ext = ~osc_ext;

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout, expected summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Upstream model: strobes derived from the counter value, cnt_dly one behind.
   function automatic logic [SAMPLE_W-1:0] word_of(input logic [15:0] c);
      return {c[4], (c % 16'd150) == 16'd0, (c % 16'd100) == 16'd0, c};
   endfunction

   function automatic logic [SAMPLE_W-1:0] exp_word(input int k);
      logic [15:0] c;
      c = 16'(k - PRE_DEPTH);
      return word_of(c);
   endfunction

   task automatic set_cnt(input logic [15:0] v);
      cnt_in     = v;
      cnt_dly_in = v - 16'd1;
      toggle     = v[4];
      hundred    = (v % 16'd100) == 16'd0;
      one_fifty  = (v % 16'd150) == 16'd0;
   endtask

   task automatic tick();
      @(posedge osc_ext);
      #1;
      set_cnt(cnt_in + 16'd1);
   endtask

   task automatic stream(input logic bp);
      logic [3:0]          pat;
      logic                rdy;
      logic                held;
      logic [SAMPLE_W-1:0] held_data;
      logic                held_last;
      int                  k;
      pat  = 4'b1001;
      held = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      k    = 0;
      for (int cyc = 0; cyc < 2000 && k < DEPTH; cyc++) begin
         rdy      = bp ? pat[cyc % 4] : 1'b1;
         rd_ready = rdy;
         if (held) begin
            chk("hold_valid", 32'(rd_valid), 32'd1);
            chk("hold_data", 32'(rd_data), 32'(held_data));
            chk("hold_last", 32'(rd_last), 32'(held_last));
         end
         held = 1'b0;
         if (rd_valid) begin
            if (rdy) begin
               chk($sformatf("word_%0d", k), 32'(rd_data), 32'(exp_word(k)));
               chk($sformatf("last_%0d", k), 32'(rd_last), 32'(k == DEPTH - 1));
               k++;
            end else begin
               held      = 1'b1;
               held_data = rd_data;
               held_last = rd_last;
            end
         end
         tick();
      end
      rd_ready = 1'b0;
      chk("stream_count", 32'(k), 32'(DEPTH));
   endtask

   task automatic capture(input logic [15:0] start, input logic bp, input logic inject);
      logic pre_trig;
      int   guard;
      set_cnt(start);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("arm_busy", 32'(busy), 32'd1);
      chk("arm_err_clear", 32'(cnt_err), 32'd0);
      pre_trig = 1'b0;
      repeat (PRE_DEPTH) begin
         tick();
         pre_trig = pre_trig | trig_seen;
      end
      chk("pre_wrap_ignored", 32'(pre_trig), 32'd0);
      // Shorten WAIT: jump the counter close to the wrap, keeping cnt_dly consistent.
      set_cnt(16'hFF00);
      if (inject) begin
         cnt_dly_in = cnt_in;
         tick();
         chk("err_set", 32'(cnt_err), 32'(CHK));
      end
      guard = 0;
      while (cnt_in != 16'hFFFA && guard < 400) begin
         tick();
         guard++;
      end
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("wait_arm_busy", 32'(busy), 32'd1);
      guard = 0;
      while (cnt_in != 16'h0000 && guard < 20) begin
         tick();
         guard++;
      end
      chk("trig_before", 32'(trig_seen), 32'd0);
      tick();
      chk("trig_after", 32'(trig_seen), 32'd1);
      repeat (DEPTH - PRE_DEPTH - 1) tick();
      chk("done_valid0", 32'(rd_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      tick();
      chk("done_valid1", 32'(rd_valid), 32'd0);
      tick();
      chk("done_valid2", 32'(rd_valid), 32'd1);
      chk("first_word", 32'(rd_data), 32'(exp_word(0)));
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("done_arm_busy", 32'(busy), 32'd1);
      chk("done_arm_valid", 32'(rd_valid), 32'd1);
      chk("done_arm_data", 32'(rd_data), 32'(exp_word(0)));
      stream(bp);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_trig", 32'(trig_seen), 32'd0);
      chk("end_valid", 32'(rd_valid), 32'd0);
      chk("err_sticky", 32'(cnt_err), 32'(CHK & inject));
   endtask

   initial begin
      int guard;
      reset    = 1'b1;
      arm      = 1'b0;
      rd_ready = 1'b0;
      set_cnt(16'h0000);
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_trig", 32'(trig_seen), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_last", 32'(rd_last), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_err", 32'(cnt_err), 32'd0);
      reset = 1'b0;
      tick();

      // Nominal capture, always ready.
      capture(16'h0010, 1'b0, 1'b0);
      // Wrap during PRE, backpressure, consistency error injected in WAIT.
      capture(16'hFFF0, 1'b1, 1'b1);

      // Reset in the middle of POST.
      set_cnt(16'h0010);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("rearm_err_clear", 32'(cnt_err), 32'd0);
      repeat (PRE_DEPTH) tick();
      set_cnt(16'hFFF8);
      guard = 0;
      while (!trig_seen && guard < 20) begin
         tick();
         guard++;
      end
      chk("midpost_trig", 32'(trig_seen), 32'd1);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_trig", 32'(trig_seen), 32'd0);
      chk("mrst_valid", 32'(rd_valid), 32'd0);
      chk("mrst_last", 32'(rd_last), 32'd0);
      chk("mrst_data", 32'(rd_data), 32'd0);
      chk("mrst_err", 32'(cnt_err), 32'd0);
      repeat (3) tick();
      chk("mrst_idle", 32'(busy), 32'd0);

      capture(16'h0010, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
